// File: rtl/sar5_rx.sv
// rtl/sar5_rx.sv - SAR 5-bit serial frame receiver with optional 4-word running sum.
// SAR5_RX_AVG_EN compiles in the word history driving avg; otherwise avg is tied to 0.
module sar5_rx (
  input  logic       clk,
  input  logic       resetn,
  input  logic       sar_serial,
  input  logic       start_ready,
  input  logic       err_clr,
  output logic [4:0] data,
  output logic       data_valid,
  output logic       busy,
  output logic       frame_err,
  output logic [7:0] frame_cnt,
  output logic [6:0] avg
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t     state, state_nxt;
  logic [2:0] bit_cnt, bit_cnt_nxt;
  logic [4:0] shreg, shreg_nxt;
  logic       abort, done;

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    shreg_nxt   = shreg;
    abort       = 1'b0;
    done        = 1'b0;
    case (state)
      IDLE: begin
        if (start_ready) begin
          state_nxt   = SHIFT;
          bit_cnt_nxt = 3'd4;
        end
      end
      SHIFT: begin
        // A start on the b0 edge is a back-to-back frame, not an abort.
        if (start_ready && (bit_cnt != 3'd0)) begin
          abort       = 1'b1;
          bit_cnt_nxt = 3'd4;
        end else begin
          shreg_nxt = (shreg << 1) | {4'b0000, sar_serial};
          if (bit_cnt == 3'd0) begin
            done        = 1'b1;
            bit_cnt_nxt = 3'd4;
            state_nxt   = start_ready ? SHIFT : IDLE;
          end else begin
            bit_cnt_nxt = bit_cnt - 3'd1;
          end
        end
      end
      default: begin
        state_nxt   = IDLE;
        bit_cnt_nxt = 3'd4;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      bit_cnt    <= 3'd4;
      shreg      <= 5'd0;
      data       <= 5'd0;
      data_valid <= 1'b0;
      busy       <= 1'b0;
      frame_err  <= 1'b0;
      frame_cnt  <= 8'd0;
    end else begin
      state      <= state_nxt;
      bit_cnt    <= bit_cnt_nxt;
      shreg      <= shreg_nxt;
      data_valid <= done;
      busy       <= (state_nxt == SHIFT);
      if (done) begin
        data      <= shreg_nxt;
        frame_cnt <= frame_cnt + 8'd1;
      end
      if (abort)
        frame_err <= 1'b1;
      else if (err_clr)
        frame_err <= 1'b0;
    end
  end

`ifdef SAR5_RX_AVG_EN
  logic [4:0] hist [4];

  // Running sum: add the incoming word, drop the one leaving the window.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 4; i++) hist[i] <= 5'd0;
      avg <= 7'd0;
    end else if (done) begin
      hist[0] <= shreg_nxt;
      for (int i = 1; i < 4; i++) hist[i] <= hist[i-1];
      avg <= avg + {2'b00, shreg_nxt} - {2'b00, hist[3]};
    end
  end
`else
  assign avg = 7'd0;
`endif

endmodule

// File: tb/tb_sar5_rx.sv
// tb/tb_sar5_rx.sv - self-checking bench for sar5_rx against a queue-based frame model.
module tb_sar5_rx;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       sar_serial = 1'b0;
  logic       start_ready = 1'b0;
  logic       err_clr = 1'b0;
  logic [4:0] data;
  logic       data_valid;
  logic       busy;
  logic       frame_err;
  logic [7:0] frame_cnt;
  logic [6:0] avg;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  sar5_rx dut (
    .clk        (clk),
    .resetn     (resetn),
    .sar_serial (sar_serial),
    .start_ready(start_ready),
    .err_clr    (err_clr),
    .data       (data),
    .data_valid (data_valid),
    .busy       (busy),
    .frame_err  (frame_err),
    .frame_cnt  (frame_cnt),
    .avg        (avg)
  );

  always #5 clk = ~clk;

  // Behavioural model: a frame is whatever bits were collected since the last start.
  bit      in_frame = 0;
  bit      bitq[$];
  int      words[$] = '{0, 0, 0, 0};
  int      m_data = 0, m_cnt = 0, m_avg = 0;
  bit      m_valid = 0, m_err = 0;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      in_frame = 0; bitq = {}; words = '{0, 0, 0, 0};
      m_data = 0; m_cnt = 0; m_avg = 0; m_valid = 0; m_err = 0;
    end else begin
      bit aborted;
      aborted = 0;
      m_valid = 0;
      if (!in_frame) begin
        if (start_ready) begin in_frame = 1; bitq = {}; end
      end else if (start_ready && bitq.size() < 4) begin
        aborted = 1; bitq = {};
      end else begin
        bitq.push_back(sar_serial);
        if (bitq.size() == 5) begin
          m_data = 0;
          foreach (bitq[i]) m_data = m_data * 2 + int'(bitq[i]);
          m_valid = 1;
          m_cnt = (m_cnt + 1) % 256;
          void'(words.pop_front());
          words.push_back(m_data);
          bitq = {};
          in_frame = start_ready;
        end
      end
      if (aborted) m_err = 1;
      else if (err_clr) m_err = 0;
`ifdef SAR5_RX_AVG_EN
      m_avg = words[0] + words[1] + words[2] + words[3];
`else
      m_avg = 0;
`endif
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    check("data", int'(data), m_data);
    check("data_valid", int'(data_valid), int'(m_valid));
    check("busy", int'(busy), int'(in_frame));
    check("frame_err", int'(frame_err), int'(m_err));
    check("frame_cnt", int'(frame_cnt), m_cnt);
    check("avg", int'(avg), m_avg);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start();
    start_ready = 1'b1;
    sar_serial  = 1'($urandom);
    tick();
    start_ready = 1'b0;
  endtask

  task automatic send_bits(input logic [4:0] w, input logic next_start);
    for (int i = 4; i >= 0; i--) begin
      sar_serial = w[i];
      if (i == 0) start_ready = next_start;
      tick();
    end
    start_ready = 1'b0;
  endtask

  initial begin
    repeat (3) tick();
    resetn = 1'b1;
    tick();
    check("reset_data", int'(data), 0);
    check("reset_cnt", int'(frame_cnt), 0);
    check("reset_busy", int'(busy), 0);

    start();
    send_bits(5'b10110, 1'b0);
    check("f1_valid", int'(data_valid), 1);
    check("f1_data", int'(data), 5'b10110);
    check("f1_cnt", int'(frame_cnt), 1);
    check("f1_err", int'(frame_err), 0);
    tick();
    check("f1_pulse_end", int'(data_valid), 0);

    start();
    send_bits(5'b11111, 1'b1);
    check("b2b_first", int'(data), 5'b11111);
    send_bits(5'b00001, 1'b0);
    check("b2b_second_valid", int'(data_valid), 1);
    check("b2b_second", int'(data), 5'b00001);
    check("b2b_cnt", int'(frame_cnt), 3);

    start();
    sar_serial = 1'b1; tick();
    sar_serial = 1'b0; tick();
    start();
    send_bits(5'b01010, 1'b0);
    check("abort_err", int'(frame_err), 1);
    check("abort_data", int'(data), 5'b01010);
    check("abort_cnt", int'(frame_cnt), 4);

    err_clr = 1'b1; tick(); err_clr = 1'b0;
    check("err_clr", int'(frame_err), 0);
    start();
    sar_serial = 1'b1; tick();
    start_ready = 1'b1; err_clr = 1'b1; tick();
    start_ready = 1'b0; err_clr = 1'b0;
    check("err_set_wins", int'(frame_err), 1);
    send_bits(5'b00000, 1'b0);
    err_clr = 1'b1; tick(); err_clr = 1'b0;

    repeat (4) begin start(); send_bits(5'd31, 1'b0); end
`ifdef SAR5_RX_AVG_EN
    check("avg_full", int'(avg), 124);
`else
    check("avg_off", int'(avg), 0);
`endif
    start(); send_bits(5'd0, 1'b0);
`ifdef SAR5_RX_AVG_EN
    check("avg_after_zero", int'(avg), 93);
`else
    check("avg_off2", int'(avg), 0);
`endif

    start();
    sar_serial = 1'b1; tick();
    tick();
    resetn = 1'b0;
    #1;
    check("async_rst_data", int'(data), 0);
    check("async_rst_cnt", int'(frame_cnt), 0);
    check("async_rst_busy", int'(busy), 0);
    tick();
    resetn = 1'b1;
    start();
    send_bits(5'b01100, 1'b0);
    check("post_rst_data", int'(data), 5'b01100);
    check("post_rst_cnt", int'(frame_cnt), 1);

    @(posedge clk); #2 resetn = 1'b0; #2 resetn = 1'b1;
    tick();
    repeat (256) begin start(); send_bits(5'($urandom), 1'b0); end
    check("cnt_wrap", int'(frame_cnt), 0);

    for (int c = 0; c < 3000; c++) begin
      start_ready = ($urandom_range(0, 6) == 0);
      sar_serial  = 1'($urandom);
      err_clr     = ($urandom_range(0, 15) == 0);
      if (c == 1500) begin
        #2 resetn = 1'b0; #2 resetn = 1'b1;
      end
      tick();
    end
    start_ready = 1'b0; err_clr = 1'b0;
    tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sar5_rx.md
SAR5_RX -- requirements
Module: sar5_rx

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk (rising edge) and resetn.
REQ-002 Port list SHALL be exactly:
- clk  input  1  system clock, rising edge
- resetn  input  1  asynchronous active-low reset
- sar_serial  input  1  serial conversion bit from the SAR controller, MSB first
- start_ready  input  1  one-cycle frame-start strobe from the SAR controller
- err_clr  input  1  synchronous clear of the sticky frame error
- data  output  5  last complete received word
- data_valid  output  1  one-cycle pulse when data is updated
- busy  output  1  high while a frame is being shifted in
- frame_err  output  1  sticky flag for a truncated frame
- frame_cnt  output  8  count of good frames received
- avg  output  7  sum of the last four words (see Configuration)

Function
REQ-003 Protocol: start_ready high at rising edge N marks frame start. sar_serial SHALL be sampled at edges N+1..N+5 as b4..b0.
REQ-004 The FSM SHALL have states IDLE, SHIFT; a 3-bit bit counter SHALL track the bit position 4..0 inside SHIFT.
REQ-005 IDLE: on start_ready=1 -> SHIFT, bit counter=4, busy=1 from the next cycle; else remain in IDLE.
REQ-006 SHIFT: each edge SHALL shift sar_serial into a 5-bit shift register and decrement the bit counter.
REQ-007 On the edge sampling b0 the block SHALL load data with {b4..b0}, pulse data_valid for exactly one cycle, increment frame_cnt, and return to IDLE.
REQ-008 Latency: data_valid SHALL be high during the cycle after edge N+5. A start_ready at edge N+5 (back-to-back frame) SHALL be accepted and start a new frame.
REQ-009 start_ready=1 in SHIFT before b0 is sampled SHALL abort the frame: set frame_err, leave data, frame_cnt and data_valid unchanged, and restart SHIFT with bit counter=4.
REQ-010 frame_cnt SHALL wrap 255 -> 0 without flagging.
REQ-011 frame_err SHALL stay high until err_clr=1. If err_clr and a new abort occur on the same edge, frame_err SHALL end high (set wins).
REQ-012 busy SHALL equal (state == SHIFT); data SHALL hold its value between frames.
REQ-013 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-014 resetn=0 SHALL asynchronously force state=IDLE, bit counter=4, shift register=0, data=0, data_valid=0, busy=0, frame_err=0, frame_cnt=0, avg=0, and clear the average history.
REQ-015 Reset asserted mid-frame SHALL discard the partial frame. The first start_ready sampled after deassertion SHALL begin a clean frame.

Configuration
REQ-016 Macro SAR5_RX_AVG_EN SHALL compile in a 4-entry word history.
REQ-017 With SAR5_RX_AVG_EN defined: on each data_valid edge the history SHALL shift in the new word. avg SHALL equal the unsigned sum of the four history entries (max 124, 7 bits), updated in the same cycle as data. History entries SHALL reset to 0.
REQ-018 Without SAR5_RX_AVG_EN: the avg port SHALL still exist, be tied to 0, and no history registers SHALL be synthesised.

Verification
REQ-019 Reset then a frame with bits 1,0,1,1,0 -> data=5'b10110, one data_valid pulse at N+6, frame_cnt=1, frame_err=0.
REQ-020 Two back-to-back frames 5'b11111 then 5'b00001 (second start at N+5) -> two valid pulses 5 cycles apart, frame_cnt=2.
REQ-021 start_ready re-asserted at N+3, then 5 bits 0,1,0,1,0 -> frame_err=1, data=5'b01010 from the restarted frame, frame_cnt increments by 1 only.
REQ-022 Pulse err_clr with no abort -> frame_err=0. err_clr on the same edge as an abort -> frame_err=1.
REQ-023 resetn pulsed low at N+3 -> all outputs 0 immediately; next full frame 5'b01100 -> data=5'b01100, frame_cnt=1. Send 256 good frames -> frame_cnt=0.
REQ-024 With SAR5_RX_AVG_EN: frames 31,31,31,31 -> avg=124; then frame 0 -> avg=93. Without the macro, avg=0 throughout.
